// File: rtl/mat_mult_if.sv
// Streaming handshake bundle for the sequential 2x2 matrix multiplier:
// an element input stream and a result output stream.
interface mat_mult_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mat_mult_seq.sv
// Sequential 2x2 matrix multiplier (8-bit, modulo-256): loads A then B serially,
// computes R = A*B over eight multiply-accumulate steps, then streams R out.
module mat_mult_seq (
    input  logic        clk,
    input  logic        rst,
    mat_mult_if.slave   bus,
    output logic [31:0] res_packed,
    output logic        busy
);

    localparam logic [1:0] LOAD    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    logic [1:0] state;
    logic [2:0] load_idx;
    logic [2:0] step;
    logic [1:0] out_idx;
    logic [7:0] acc;

    logic [7:0] a_mat [0:3];
    logic [7:0] b_mat [0:3];
    logic [7:0] r_mat [0:3];

    logic       in_fire;
    logic       out_fire;
    logic [7:0] a_sel;
    logic [7:0] b_sel;
    logic [7:0] prod;
    logic [7:0] sum;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    // Step encodes {i,j,k}: A[i][k] lives at slot {i,k}, B[k][j] at slot {k,j}.
    assign a_sel = a_mat[{step[2], step[0]}];
    assign b_sel = b_mat[{step[0], step[1]}];
    assign prod  = a_sel * b_sel;
    assign sum   = (step[0] ? acc : 8'd0) + prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            load_idx <= 3'd0;
            step     <= 3'd0;
            out_idx  <= 2'd0;
            acc      <= 8'd0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        load_idx <= load_idx + 3'd1;
                        if (load_idx == 3'd7) begin
                            state <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    step <= step + 3'd1;
                    acc  <= sum;
                    if (step == 3'd7) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        out_idx <= out_idx + 2'd1;
                        if (out_idx == 2'd3) begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // The first four accepted elements fill A, the next four fill B.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                a_mat[n] <= 8'd0;
                b_mat[n] <= 8'd0;
            end
        end else if (in_fire) begin
            if (!load_idx[2]) begin
                a_mat[load_idx[1:0]] <= bus.in_data;
            end else begin
                b_mat[load_idx[1:0]] <= bus.in_data;
            end
        end
    end

    // R11 is completed by the final step, so the packed result takes it from sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                r_mat[n] <= 8'd0;
            end
            res_packed <= 32'd0;
        end else if (state == COMPUTE) begin
            if (step[0]) begin
                r_mat[step[2:1]] <= sum;
            end
            if (step == 3'd7) begin
                res_packed <= {r_mat[0], r_mat[1], r_mat[2], sum};
            end
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_data  = (state == DRAIN) ? r_mat[out_idx] : 8'd0;
    assign bus.out_last  = (state == DRAIN) && (out_idx == 2'd3);
    assign busy          = (state != LOAD);

endmodule

// File: tb/tb_mat_mult_seq.sv
// Scoreboard bench for mat_mult_seq: stimulus pushes reference results into queues,
// an independent negedge monitor pops and compares whenever a result is handed off.
module tb_mat_mult_seq;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         hold;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] res_packed;
    logic        busy;

    mat_mult_if bus ();

    mat_mult_seq dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .res_packed (res_packed),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_res_q[$];
    logic [31:0] last_res;

    bit rand_ready = 0;
    bit force_low  = 0;
    int stall_pos  = -1;
    int stall_left = 0;
    int item_pos   = 0;

    int         cyc = 0;
    int         in_count = 0;
    int         last_hs_cyc = 0;
    bit         lat_armed = 0;
    bit         busy_exp = 0;
    bit         post_last = 0;
    bit         prev_valid = 0;
    bit         prev_hs = 0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;
    int         hold_cnt = 0;
    exp_t       mon_e;
    logic [31:0] mon_res;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Plain matrix product R = A*B with results reduced modulo 256.
    function automatic logic [31:0] refMult(input logic [63:0] elems);
        int a[2][2];
        int b[2][2];
        int r;
        logic [31:0] res;
        res = 32'd0;
        for (int n = 0; n < 4; n++) begin
            a[n / 2][n % 2] = int'(elems[63 - 8 * n -: 8]);
            b[n / 2][n % 2] = int'(elems[31 - 8 * n -: 8]);
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                r = 0;
                for (int k = 0; k < 2; k++) begin
                    r += a[i][k] * b[k][j];
                end
                res[31 - 8 * (2 * i + j) -: 8] = 8'(r % 256);
            end
        end
        return res;
    endfunction

    task automatic applyStimulus(input logic [63:0] elems, input int gap_pos,
                                 input int gap_len, input bit rand_gaps);
        logic [31:0] res;
        exp_t        e;
        bit          got;
        int          waited;
        int          gaps;
        res = refMult(elems);
        for (int n = 0; n < 4; n++) begin
            e.data = res[31 - 8 * n -: 8];
            e.last = (n == 3);
            if (rand_ready) e.hold = 0;
            else if (n == stall_pos && stall_left > 0) e.hold = stall_left + 1;
            else e.hold = 1;
            exp_q.push_back(e);
        end
        exp_res_q.push_back(res);
        last_res = res;
        for (int n = 0; n < 8; n++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = elems[63 - 8 * n -: 8];
            got    = 0;
            waited = 0;
            while (!got && waited < 1000) begin
                @(negedge clk);
                got = bus.in_ready && !rst;
                @(posedge clk);
                #1;
                waited++;
            end
            if (!got) begin
                checkOutput("in_handshake_timeout", 32'(waited), 32'd0);
                bus.in_valid = 1'b0;
                return;
            end
            gaps = (n == gap_pos) ? gap_len : 0;
            if (rand_gaps && n != 7) gaps = gaps + int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic waitDrained(input int limit);
        for (int c = 0; c < limit && exp_q.size() != 0; c++) begin
            @(negedge clk);
        end
        checkOutput("drain_done", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_res_q.delete();
        repeat (3) @(negedge clk);
        checkOutput("res_hold", res_packed, last_res);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        exp_res_q.delete();
        @(negedge clk);
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_last",  32'(bus.out_last),  32'd0);
        checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
        checkOutput("rst_res_packed", res_packed,        32'd0);
        checkOutput("rst_busy",      32'(busy),          32'd0);
        @(posedge clk);
        #1;
    endtask

    // Downstream model: optional random back-pressure and a targeted stall.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) item_pos = 0;
            else if (bus.out_valid && bus.out_ready) item_pos = (item_pos + 1) % 4;
            @(posedge clk);
            #1;
            if (force_low) begin
                bus.out_ready = 1'b0;
            end else if (stall_left > 0 && bus.out_valid && item_pos == stall_pos) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: busy/ready timing model, output scoreboard, hold and latency checks.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_count   = 0;
            lat_armed  = 0;
            busy_exp   = 0;
            post_last  = 0;
            prev_valid = 0;
            prev_hs    = 0;
            hold_cnt   = 0;
        end else begin
            checkOutput("busy", 32'(busy), 32'(busy_exp));
            checkOutput("in_ready", 32'(bus.in_ready), 32'(!busy_exp));
            if (post_last) begin
                checkOutput("after_last", 32'({bus.in_ready, bus.out_valid}), 32'd2);
                post_last = 0;
            end
            if (!bus.out_valid) begin
                checkOutput("idle_out", 32'({bus.out_last, bus.out_data}), 32'd0);
            end else begin
                if (!prev_valid && lat_armed) begin
                    checkOutput("latency", 32'(cyc - last_hs_cyc), 32'd9);
                    lat_armed = 0;
                end
                if (prev_valid && !prev_hs) begin
                    checkOutput("hold_stable", 32'({bus.out_last, bus.out_data}),
                                32'({prev_last, prev_data}));
                end
                hold_cnt++;
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("out_data", 32'(bus.out_data), 32'(mon_e.data));
                        checkOutput("out_last", 32'(bus.out_last), 32'(mon_e.last));
                        if (mon_e.hold > 0) begin
                            checkOutput("hold_cycles", 32'(hold_cnt), 32'(mon_e.hold));
                        end
                        if (mon_e.last) begin
                            mon_res = (exp_res_q.size() != 0) ? exp_res_q.pop_front() : 32'd0;
                            checkOutput("res_packed", res_packed, mon_res);
                            post_last = 1;
                            busy_exp  = 0;
                        end
                    end
                    hold_cnt = 0;
                end
            end
            prev_valid = bus.out_valid;
            prev_hs    = bus.out_valid && bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (bus.in_valid && bus.in_ready) begin
                in_count++;
                if (in_count == 8) begin
                    in_count    = 0;
                    last_hs_cyc = cyc;
                    lat_armed   = 1;
                    busy_exp    = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        last_res     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        pulseReset();

        // V1: basic product with full-rate output.
        applyStimulus(64'h0102_0304_0506_0708, -1, 0, 0);
        waitDrained(200);
        checkOutput("v1_res_value", res_packed, 32'h1316_2B32);

        // V2: every product wraps modulo 256.
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 0);
        waitDrained(200);
        checkOutput("v2_res_value", res_packed, 32'h0202_0202);

        // V3: identity times B with an input gap after A11.
        applyStimulus(64'h0100_0001_0908_0706, 3, 2, 0);
        waitDrained(200);

        // V4: stall the second result for three cycles.
        stall_pos  = 1;
        stall_left = 3;
        applyStimulus(64'h0102_0304_0506_0708, -1, 0, 0);
        waitDrained(200);
        stall_pos  = -1;
        stall_left = 0;

        // V5: reset during COMPUTE step 4, then load V3 data.
        applyStimulus(64'h0102_0304_0506_0708, -1, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        pulseReset();
        applyStimulus(64'h0100_0001_0908_0706, 3, 2, 0);
        waitDrained(200);
        checkOutput("v5_res_value", res_packed, 32'h0908_0706);

        // V6: back-to-back V1 then V2.
        applyStimulus(64'h0102_0304_0506_0708, -1, 0, 0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 0);
        waitDrained(300);

        // Reset mid-LOAD with a handshake pending, then V1 must still start at A00.
        bus.in_valid = 1'b1;
        repeat (3) begin
            bus.in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        pulseReset();
        applyStimulus(64'h0102_0304_0506_0708, -1, 0, 0);
        waitDrained(200);

        // Reset mid-DRAIN while the output is back-pressured.
        force_low = 1;
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 0);
        repeat (12) @(posedge clk);
        #1;
        pulseReset();
        force_low = 0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;

        // Randomized matrices, input gaps and output back-pressure.
        rand_ready = 1;
        for (int t = 0; t < 16; t++) begin
            applyStimulus({$urandom, $urandom}, -1, 0, 1);
            waitDrained(400);
        end
        rand_ready = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
